// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the parametrised binary-to-BCD converter.
package bin2bcd_pkg;

  // Controller states; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP   = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Double-dabble correction: digits above 4 get 3 added before the shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd4;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit slice of the shift-and-add-3 datapath: correct, then shift in a carry.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_carry,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  logic [3:0] w_adj;

  // Add-3 correction followed by a one-bit left shift; adj[3] ripples to the next digit.
  always_comb begin
    w_adj   = (i_digit > BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;
    o_digit = {w_adj[2:0], i_carry};
    o_carry = w_adj[3];
  end

endmodule

// File: rtl/bin2bcd_param.sv
// Multi-cycle binary-to-BCD converter with optional signed input, sticky overflow
// and a leading-zero blank mask. One input bit is consumed per OP cycle.
module bin2bcd_param
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W    = 13,
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SIGNED   = 0
) (
  input  logic                    clk_amisha,
  input  logic                    reset_amisha,
  input  logic                    start_amisha,
  input  logic [BIN_W-1:0]        bin_amisha,
  output logic                    ready_amisha,
  output logic                    done_tick_amisha,
  output logic [4*N_DIGITS-1:0]   bcd_amisha,
  output logic                    neg_amisha,
  output logic                    ovf_amisha,
  output logic [N_DIGITS-1:0]     blank_amisha
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_e                  r_state;
  logic [BIN_W-1:0]        r_shift;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*N_DIGITS-1:0]   r_bcd;
  logic                    r_neg;
  logic                    r_ovf;

  logic [BIN_W-1:0]        w_mag;
  logic                    w_neg_in;
  logic [CNT_W-1:0]        w_cnt_dec;
  logic [4*N_DIGITS-1:0]   w_bcd_next;
  logic                    w_ovf_step;
  logic [N_DIGITS-1:0]     w_blank;
  logic                    w_zero_above;

  // Sign and magnitude of the incoming value; the most-negative input wraps to 2^(BIN_W-1).
  always_comb begin
    w_neg_in = (SIGNED != 0) && bin_amisha[BIN_W-1];
    w_mag    = w_neg_in ? (~bin_amisha + {{(BIN_W-1){1'b0}}, 1'b1}) : bin_amisha;
  end

  assign w_cnt_dec = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};

  // Chain of digit slices; digit 0 takes the shift register MSB as its carry-in.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dig
    logic       w_cin;
    logic       w_cout;
    logic [3:0] w_next;

    if (gi == 0) begin : g_first
      assign w_cin = r_shift[BIN_W-1];
    end else begin : g_rest
      assign w_cin = g_dig[gi-1].w_cout;
    end

    bcd_digit_adj u_adj (
      .i_digit (r_bcd[4*gi +: 4]),
      .i_carry (w_cin),
      .o_digit (w_next),
      .o_carry (w_cout)
    );

    assign w_bcd_next[4*gi +: 4] = w_next;
  end

  // A carry out of the top digit means the value no longer fits.
  assign w_ovf_step = g_dig[N_DIGITS-1].w_cout;

  // Controller and datapath registers; bcd/neg/ovf hold the last result while idle.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_amisha) begin
            r_shift <= w_mag;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_neg   <= w_neg_in;
            r_cnt   <= CNT_W'(BIN_W);
            r_state <= ST_OP;
          end
        end
        ST_OP: begin
          r_bcd   <= w_bcd_next;
          r_shift <= {r_shift[BIN_W-2:0], 1'b0};
          r_cnt   <= w_cnt_dec;
          r_ovf   <= r_ovf | w_ovf_step;
          if (w_cnt_dec == '0) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Blank digit i when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_bcd[4*i +: 4] == 4'd0);
      w_blank[i]   = w_zero_above;
    end
  end

  assign ready_amisha     = (r_state == ST_IDLE);
  assign done_tick_amisha = (r_state == ST_DONE);
  assign bcd_amisha       = r_bcd;
  assign neg_amisha       = r_neg;
  assign ovf_amisha       = r_ovf;
  assign blank_amisha     = w_blank;

endmodule

// File: tb/tb_bin2bcd_param.sv
// Bench for bin2bcd_param: three configurations (default, 3 digits, signed) checked
// against an arithmetic reference model with directed and random conversions.
module tb_bin2bcd_param;

  logic        clk_amisha = 1'b0;
  logic        reset_amisha;
  logic        s0, s1, s2;
  logic [12:0] b0, b1, b2;
  logic        rdy0, rdy1, rdy2, dn0, dn1, dn2;
  logic        ng0, ng1, ng2, ov0, ov1, ov2;
  logic [15:0] bcd0, bcd2;
  logic [11:0] bcd1;
  logic [3:0]  bl0, bl2;
  logic [2:0]  bl1;

  int n_cmp  = 0;
  int n_fail = 0;
  int dcnt0  = 0;

  always #5 clk_amisha = ~clk_amisha;

  bin2bcd_param #(.BIN_W(13), .N_DIGITS(4), .SIGNED(0)) u_dut0 (
    .clk_amisha(clk_amisha), .reset_amisha(reset_amisha), .start_amisha(s0),
    .bin_amisha(b0), .ready_amisha(rdy0), .done_tick_amisha(dn0), .bcd_amisha(bcd0),
    .neg_amisha(ng0), .ovf_amisha(ov0), .blank_amisha(bl0)
  );

  bin2bcd_param #(.BIN_W(13), .N_DIGITS(3), .SIGNED(0)) u_dut1 (
    .clk_amisha(clk_amisha), .reset_amisha(reset_amisha), .start_amisha(s1),
    .bin_amisha(b1), .ready_amisha(rdy1), .done_tick_amisha(dn1), .bcd_amisha(bcd1),
    .neg_amisha(ng1), .ovf_amisha(ov1), .blank_amisha(bl1)
  );

  bin2bcd_param #(.BIN_W(13), .N_DIGITS(4), .SIGNED(1)) u_dut2 (
    .clk_amisha(clk_amisha), .reset_amisha(reset_amisha), .start_amisha(s2),
    .bin_amisha(b2), .ready_amisha(rdy2), .done_tick_amisha(dn2), .bcd_amisha(bcd2),
    .neg_amisha(ng2), .ovf_amisha(ov2), .blank_amisha(bl2)
  );

  // Count done pulses of the default instance for the abort / ignored-start steps.
  always @(posedge clk_amisha) begin
    if (dn0) dcnt0 <= dcnt0 + 1;
  end

  function automatic logic obs_rdy(input int d);
    case (d) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
  endfunction
  function automatic logic obs_dn(input int d);
    case (d) 0: return dn0; 1: return dn1; default: return dn2; endcase
  endfunction
  function automatic logic obs_neg(input int d);
    case (d) 0: return ng0; 1: return ng1; default: return ng2; endcase
  endfunction
  function automatic logic obs_ovf(input int d);
    case (d) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction
  function automatic logic [15:0] obs_bcd(input int d);
    case (d) 0: return bcd0; 1: return {4'h0, bcd1}; default: return bcd2; endcase
  endfunction
  function automatic logic [3:0] obs_blank(input int d);
    case (d) 0: return bl0; 1: return {1'b0, bl1}; default: return bl2; endcase
  endfunction

  task automatic set_in(input int d, input logic st, input logic [12:0] v);
    case (d)
      0: begin s0 = st; b0 = v; end
      1: begin s1 = st; b1 = v; end
      default: begin s2 = st; b2 = v; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of the magnitude by plain division.
  task automatic model(input int d, input logic [12:0] v, output logic [15:0] e_bcd,
                       output logic e_neg, output logic e_ovf, output logic [3:0] e_blank);
    int nd;
    int mag;
    int lim;
    int r;
    int p;
    nd    = (d == 1) ? 3 : 4;
    mag   = int'(v);
    e_neg = (d == 2) && v[12];
    if (e_neg) mag = 8192 - mag;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    e_ovf = (mag >= lim);
    r     = mag % lim;
    e_bcd = '0;
    for (int k = 0; k < nd; k++) begin
      e_bcd[4*k +: 4] = 4'((r / (10 ** k)) % 10);
    end
    // Digit k blanks exactly when the shown value is below 10^k.
    e_blank = '0;
    p = 1;
    for (int k = 1; k < nd; k++) begin
      p = p * 10;
      e_blank[k] = (r < p);
    end
  endtask

  task automatic check_result(input int d, input logic [12:0] v, input string tag);
    logic [15:0] e_bcd;
    logic        e_neg, e_ovf;
    logic [3:0]  e_blank;
    model(d, v, e_bcd, e_neg, e_ovf, e_blank);
    check($sformatf("%s bcd d%0d v=%0d", tag, d, v), 32'(obs_bcd(d)), 32'(e_bcd));
    check($sformatf("%s neg d%0d v=%0d", tag, d, v), 32'(obs_neg(d)), 32'(e_neg));
    check($sformatf("%s ovf d%0d v=%0d", tag, d, v), 32'(obs_ovf(d)), 32'(e_ovf));
    check($sformatf("%s blank d%0d v=%0d", tag, d, v), 32'(obs_blank(d)), 32'(e_blank));
  endtask

  // One full conversion; entered and left at a falling edge with the DUT idle.
  task automatic do_conv(input int d, input logic [12:0] v);
    int cyc;
    check($sformatf("ready_idle d%0d", d), 32'(obs_rdy(d)), 32'd1);
    set_in(d, 1'b1, v);
    @(negedge clk_amisha);
    set_in(d, 1'b0, v);
    cyc = 1;
    check($sformatf("ready_busy d%0d", d), 32'(obs_rdy(d)), 32'd0);
    while (!obs_dn(d) && cyc < 40) begin
      @(negedge clk_amisha);
      cyc++;
    end
    check($sformatf("latency d%0d v=%0d", d, v), 32'(cyc), 32'd14);
    check_result(d, v, "conv");
    @(negedge clk_amisha);
    check($sformatf("ready_back d%0d", d), 32'(obs_rdy(d)), 32'd1);
    check($sformatf("done_single d%0d", d), 32'(obs_dn(d)), 32'd0);
  endtask

  initial begin
    int cyc;
    int d_before;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    b0 = '0; b1 = '0; b2 = '0;
    reset_amisha = 1'b1;
    repeat (3) @(negedge clk_amisha);
    reset_amisha = 1'b0;
    @(negedge clk_amisha);

    // Reset state of all three configurations.
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst ready d%0d", d), 32'(obs_rdy(d)), 32'd1);
      check($sformatf("rst done d%0d", d), 32'(obs_dn(d)), 32'd0);
      check_result(d, 13'd0, "rst");
    end

    // Full-scale default conversion, zero, and the signed corner values.
    do_conv(0, 13'd8191);
    do_conv(0, 13'd0);
    do_conv(1, 13'd1234);
    do_conv(1, 13'd999);
    do_conv(2, 13'h1FFF);
    do_conv(2, 13'h1000);
    do_conv(2, 13'h0FFF);

    // Back-to-back with start held high: one idle cycle between conversions.
    set_in(0, 1'b1, 13'd7);
    @(negedge clk_amisha);
    cyc = 1;
    while (!dn0 && cyc < 40) begin @(negedge clk_amisha); cyc++; end
    check("b2b first latency", 32'(cyc), 32'd14);
    check_result(0, 13'd7, "b2b1");
    set_in(0, 1'b1, 13'd40);
    @(negedge clk_amisha);
    check("b2b idle gap ready", 32'(rdy0), 32'd1);
    @(negedge clk_amisha);
    check("b2b second busy", 32'(rdy0), 32'd0);
    cyc = 1;
    while (!dn0 && cyc < 40) begin @(negedge clk_amisha); cyc++; end
    check("b2b second latency", 32'(cyc), 32'd14);
    check_result(0, 13'd40, "b2b2");
    set_in(0, 1'b0, 13'd40);
    @(negedge clk_amisha);
    check("b2b end ready", 32'(rdy0), 32'd1);

    // Asynchronous reset in OP cycle 6 aborts without a done pulse.
    set_in(0, 1'b1, 13'd5000);
    @(negedge clk_amisha);
    set_in(0, 1'b0, 13'd5000);
    repeat (5) @(negedge clk_amisha);
    d_before = dcnt0;
    #2 reset_amisha = 1'b1;
    @(negedge clk_amisha);
    #1 reset_amisha = 1'b0;
    @(negedge clk_amisha);
    check("abort ready", 32'(rdy0), 32'd1);
    check_result(0, 13'd0, "abort");
    repeat (20) @(negedge clk_amisha);
    check("abort no done", 32'(dcnt0 - d_before), 32'd0);
    do_conv(0, 13'd42);

    // Start pulses during OP and DONE are ignored.
    d_before = dcnt0;
    set_in(0, 1'b1, 13'd1234);
    @(negedge clk_amisha);
    set_in(0, 1'b0, 13'd1234);
    repeat (3) @(negedge clk_amisha);
    set_in(0, 1'b1, 13'd999);
    @(negedge clk_amisha);
    set_in(0, 1'b0, 13'd999);
    cyc = 5;
    while (!dn0 && cyc < 40) begin @(negedge clk_amisha); cyc++; end
    check("ignore latency", 32'(cyc), 32'd14);
    set_in(0, 1'b1, 13'd77);
    @(negedge clk_amisha);
    set_in(0, 1'b0, 13'd77);
    check("ignore idle ready", 32'(rdy0), 32'd1);
    repeat (20) @(negedge clk_amisha);
    check("ignore still idle", 32'(rdy0), 32'd1);
    check("ignore one done", 32'(dcnt0 - d_before), 32'd1);
    check_result(0, 13'd1234, "ignore");

    // Random conversions on every configuration.
    for (int i = 0; i < 15; i++) begin
      for (int d = 0; d < 3; d++) begin
        do_conv(d, 13'($urandom_range(0, 8191)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_param.md
Name: bin2bcd_param

Overview:
Parametrised, multi-cycle binary-to-BCD converter (shift-and-add-3 / double-dabble FSMD). It is the next-generation replacement for the fixed 13-bit, 4-digit converter.
- Generalised input width and digit count.
- Optional two's-complement signed input.
- Sticky overflow flag when the value exceeds the digit capacity.
- Per-digit leading-zero blank mask for display drivers.
- Sits between arithmetic/counter logic and 7-segment or LCD display multiplexers, using the same start/ready/done_tick handshake.

Parameters:
BIN_W, 13, binary input width in bits (>=2).
N_DIGITS, 4, number of BCD output digits (>=1).
SIGNED, 0, 1 = bin input is two's complement (sign/magnitude output); 0 = unsigned.

Ports:
clk_amisha  in  1  clock, rising edge.
reset_amisha  in  1  asynchronous, active-high reset.
start_amisha  in  1  conversion request; sampled only in IDLE.
bin_amisha  in  BIN_W  binary value; captured on the accepted start.
ready_amisha  out  1  high while in IDLE (combinational from state).
done_tick_amisha  out  1  one-cycle pulse in DONE state.
bcd_amisha  out  4*N_DIGITS  packed BCD result; digit 0 in [3:0], digit i in [4i+3:4i]; registered.
neg_amisha  out  1  result is negative (SIGNED=1 only; tied 0 when SIGNED=0); registered.
ovf_amisha  out  1  magnitude >= 10^N_DIGITS; registered, sticky within one conversion.
blank_amisha  out  N_DIGITS  bit i=1 when digit i and all higher digits are 0; bit 0 always 0.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, bcd=0, neg=0, ovf=0;
  - shift register=0, counter=0;
  - blank = all ones except bit 0; ready=1; done_tick=0.
- Reset asserted mid-conversion aborts it. No done_tick is issued; the bench sees ready=1 on the first edge after deassertion.
- States: IDLE, OP, DONE. Encoding comes from the package.
- IDLE:
  - ready=1.
  - On start=1 at a rising edge, the block loads:
    - shift reg = magnitude(bin);
    - bcd=0, ovf=0;
    - neg = SIGNED & bin[BIN_W-1];
    - counter = BIN_W.
  - Then go to OP.
  - Outputs hold the previous result until start is accepted.
- Magnitude when SIGNED=1 and MSB set: shift reg = (~bin + 1) truncated to BIN_W bits unsigned. The most-negative input (-2^(BIN_W-1)) gives magnitude 2^(BIN_W-1) correctly. Otherwise magnitude = bin.
- OP, one bit per cycle:
  - Each digit: adj_i = (digit_i > 4) ? digit_i + 3 : digit_i.
  - New digit_i = {adj_i[2:0], carry-in}. Carry-in for digit 0 is the shift reg MSB; for digit i>0 it is adj_{i-1}[3].
  - Shift reg <<1; counter -1.
  - adj_{N_DIGITS-1}[3] == 1 sets ovf (sticky OR).
  - When the decremented counter == 0, go to DONE.
  - OP lasts exactly BIN_W cycles.
- DONE: done_tick=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: start edge to done_tick high = BIN_W+1 cycles. Total busy time is BIN_W+2 cycles until ready returns.
- On overflow, bcd = magnitude mod 10^N_DIGITS and ovf=1.
- Counter width is $clog2(BIN_W+1).
- start during OP or DONE is ignored (no queueing). start held high continuously gives back-to-back conversions, with one IDLE cycle between them.
- blank is combinational from the bcd register, so it is valid whenever bcd is valid.
- bcd/neg/ovf are stable and valid from the DONE cycle until the next accepted start.
- Illegal state encoding goes to IDLE.

Decomposition:
- Package bin2bcd_pkg:
  - state localparams ST_IDLE=2'b00, ST_OP=2'b01, ST_DONE=2'b10;
  - BCD_ADJ_THRESH=4, BCD_ADJ_ADD=3.
- One sub-module, bcd_digit_adj: 4-bit in, 1-bit carry-in. Outputs the next 4-bit digit and the carry-out (adj[3]). It is generate-instantiated N_DIGITS times and chained.
- FSM, counter, magnitude, ovf and blank logic stay in bin2bcd_param.

Test Plan:
1. Defaults (13,4,0): reset, then start with bin=8191 -> done_tick exactly 14 cycles after the start edge; bcd=16'h8191, ovf=0, neg=0, blank=4'b0000.
2. Defaults: bin=0 -> bcd=16'h0000, blank=4'b1110; bin=7, then bin=40 back-to-back with start held high -> bcd=16'h0007 (blank 1110), then 16'h0040 (blank 1100). ready low during each conversion, high for 1 cycle between.
3. N_DIGITS=3: bin=1234 -> bcd=12'h234, ovf=1; next bin=999 -> bcd=12'h999, ovf=0 (ovf cleared on start).
4. SIGNED=1, BIN_W=13: bin=13'h1FFF -> bcd=16'h0001, neg=1; bin=13'h1000 -> bcd=16'h4096, neg=1; bin=13'h0FFF -> bcd=16'h4095, neg=0.
5. Mid-op reset: start with bin=5000, assert reset_amisha asynchronously (off clock edge) in OP cycle 6 -> bcd=0, ovf=0, no done_tick, ready=1 after release; then bin=42 -> bcd=16'h0042.
6. start pulsed during OP and DONE -> ignored; exactly one done_tick per accepted start; result matches the first-captured bin.
